// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fpu_pkg
// Purpose  : Shared types and constants for the FPU operation sequencer:
//            sequencer state encoding, op-code values, IEEE flag width.
// Revision : 1.0 - initial release
// ============================================================================
package fpu_pkg;

    // Sequencer states. IDLE is all-zeros so reset and "not busy" coincide.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } fpu_seq_state_t;

    // Operation codes understood by the FPU core.
    localparam int unsigned FPU_ADD     = 0;
    localparam int unsigned FPU_SUB     = 1;
    localparam int unsigned FPU_MUL     = 2;
    localparam int unsigned FPU_DIV     = 3;
    localparam int unsigned FPU_SQRT    = 4;
    localparam int unsigned FPU_OP_LAST = 4;

    // IEEE exception flags: NV, DZ, OF, UF, NX.
    localparam int unsigned FPU_FLAG_WIDTH = 5;

endpackage : fpu_pkg
`default_nettype wire

// File: rtl/fpu_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : fpu_watchdog
// Purpose  : Saturating cycle counter that flags when an operation has been
//            outstanding for TIMEOUT_CYCLES cycles. The count advances on
//            every cycle that run is high and sticks at its limit.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam int c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_CNT_W-1:0] count_q;
    logic [c_CNT_W-1:0] count_d;

    // Next count: clear wins, otherwise step while running until the limit.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (run && (count_q != c_LIMIT)) begin
            count_d = count_q + c_CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Expiry is only meaningful while an operation is outstanding.
    assign expired = run && (count_q == c_LIMIT);

endmodule : fpu_watchdog
`default_nettype wire

// File: rtl/fpu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fpu_op_sequencer
// Purpose  : Runs one FPU operation per START: latches operands/op code,
//            issues them over valid/ready, waits for the result under a
//            watchdog, captures result/flags and reports sticky status and
//            an interrupt back to the register side.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_op_sequencer
    import fpu_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int OPSEL_WIDTH    = 3,
    parameter int FLAG_WIDTH     = FPU_FLAG_WIDTH,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   START,
    input  logic                   CLEAR,
    input  logic                   IRQ_EN,
    input  logic [DATA_WIDTH-1:0]  OP1_IN,
    input  logic [DATA_WIDTH-1:0]  OP2_IN,
    input  logic [OPSEL_WIDTH-1:0] OP_SEL_IN,
    output logic                   FPU_VALID,
    input  logic                   FPU_READY,
    output logic [DATA_WIDTH-1:0]  FPU_OP1,
    output logic [DATA_WIDTH-1:0]  FPU_OP2,
    output logic [OPSEL_WIDTH-1:0] FPU_OPSEL,
    input  logic                   FPU_RESULT_VALID,
    input  logic [DATA_WIDTH-1:0]  FPU_RESULT,
    input  logic [FLAG_WIDTH-1:0]  FPU_FLAGS,
    output logic [DATA_WIDTH-1:0]  RESULT,
    output logic [FLAG_WIDTH-1:0]  FLAGS,
    output logic                   BUSY,
    output logic                   DONE,
    output logic                   TIMEOUT_ERR,
    output logic                   ILLEGAL_OP,
    output logic                   OVERRUN,
    output logic                   IRQ
);

    localparam logic [OPSEL_WIDTH-1:0] c_OP_LAST = OPSEL_WIDTH'(FPU_OP_LAST);

    fpu_seq_state_t             state_q,     state_d;
    logic                       fpu_valid_q, fpu_valid_d;
    logic [DATA_WIDTH-1:0]      fpu_op1_q,   fpu_op1_d;
    logic [DATA_WIDTH-1:0]      fpu_op2_q,   fpu_op2_d;
    logic [OPSEL_WIDTH-1:0]     fpu_opsel_q, fpu_opsel_d;
    logic [DATA_WIDTH-1:0]      result_q,    result_d;
    logic [FLAG_WIDTH-1:0]      flags_q,     flags_d;
    logic                       done_q,      done_d;
    logic                       timeout_q,   timeout_d;
    logic                       illegal_q,   illegal_d;
    logic                       overrun_q,   overrun_d;

    logic w_op_legal;
    logic w_start_ok;
    logic w_done_set;
    logic w_timeout_set;
    logic w_illegal_set;
    logic w_overrun_set;
    logic w_wd_clr;
    logic w_wd_run;
    logic w_wd_expired;

    assign w_op_legal = (OP_SEL_IN <= c_OP_LAST);
    assign w_wd_run   = (state_q != IDLE);

    fpu_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (CLK),
        .rst     (RST),
        .clr     (w_wd_clr),
        .run     (w_wd_run),
        .expired (w_wd_expired)
    );

    // Next-state, datapath capture and sticky-status logic.
    always_comb begin
        state_d       = state_q;
        fpu_valid_d   = fpu_valid_q;
        fpu_op1_d     = fpu_op1_q;
        fpu_op2_d     = fpu_op2_q;
        fpu_opsel_d   = fpu_opsel_q;
        result_d      = result_q;
        flags_d       = flags_q;
        w_start_ok    = 1'b0;
        w_done_set    = 1'b0;
        w_timeout_set = 1'b0;
        w_illegal_set = 1'b0;
        w_overrun_set = 1'b0;
        w_wd_clr      = 1'b0;

        case (state_q)
            IDLE: begin
                if (START) begin
                    if (w_op_legal) begin
                        w_start_ok  = 1'b1;
                        w_wd_clr    = 1'b1;
                        fpu_op1_d   = OP1_IN;
                        fpu_op2_d   = OP2_IN;
                        fpu_opsel_d = OP_SEL_IN;
                        fpu_valid_d = 1'b1;
                        state_d     = ISSUE;
                    end else begin
                        // Unsupported op code: flag it, never issue.
                        w_illegal_set = 1'b1;
                    end
                end
            end
            ISSUE: begin
                w_overrun_set = START;
                // An expiry in ISSUE abandons the request even if READY
                // arrives in the same cycle.
                if (w_wd_expired) begin
                    w_timeout_set = 1'b1;
                    fpu_valid_d   = 1'b0;
                    state_d       = IDLE;
                end else if (FPU_READY) begin
                    fpu_valid_d   = 1'b0;
                    state_d       = WAIT;
                end
            end
            WAIT: begin
                w_overrun_set = START;
                // A result on the expiry cycle still counts as completion.
                if (FPU_RESULT_VALID) begin
                    result_d   = FPU_RESULT;
                    flags_d    = FPU_FLAGS;
                    w_done_set = 1'b1;
                    state_d    = IDLE;
                end else if (w_wd_expired) begin
                    w_timeout_set = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: begin
                fpu_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase

        // Sticky bits: a set in the same cycle as CLEAR takes precedence.
        // An accepted START wipes the previous outcome but not OVERRUN.
        done_d    = w_done_set    | (done_q    & ~CLEAR & ~w_start_ok);
        timeout_d = w_timeout_set | (timeout_q & ~CLEAR & ~w_start_ok);
        illegal_d = w_illegal_set | (illegal_q & ~CLEAR & ~w_start_ok);
        overrun_d = w_overrun_set | (overrun_q & ~CLEAR);
    end

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            fpu_valid_q <= 1'b0;
            fpu_op1_q   <= '0;
            fpu_op2_q   <= '0;
            fpu_opsel_q <= '0;
            result_q    <= '0;
            flags_q     <= '0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            illegal_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            fpu_valid_q <= fpu_valid_d;
            fpu_op1_q   <= fpu_op1_d;
            fpu_op2_q   <= fpu_op2_d;
            fpu_opsel_q <= fpu_opsel_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            illegal_q   <= illegal_d;
            overrun_q   <= overrun_d;
        end
    end

    assign FPU_VALID   = fpu_valid_q;
    assign FPU_OP1     = fpu_op1_q;
    assign FPU_OP2     = fpu_op2_q;
    assign FPU_OPSEL   = fpu_opsel_q;
    assign RESULT      = result_q;
    assign FLAGS       = flags_q;
    assign DONE        = done_q;
    assign TIMEOUT_ERR = timeout_q;
    assign ILLEGAL_OP  = illegal_q;
    assign OVERRUN     = overrun_q;
    assign BUSY        = (state_q != IDLE);
    assign IRQ         = IRQ_EN & (done_q | timeout_q | illegal_q);

endmodule : fpu_op_sequencer
`default_nettype wire

// File: tb/tb_fpu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_op_sequencer
// Purpose  : Self-checking bench for fpu_op_sequencer. Each transaction is
//            described by when the FPU core answers; the expected handshake
//            and final status are derived from those timings and queued,
//            and a monitor compares them when the DUT produces them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_op_sequencer;

    localparam int DW = 32;
    localparam int OW = 3;
    localparam int FW = 5;
    localparam int T  = 16;

    logic          CLK = 1'b0;
    logic          RST;
    logic          START;
    logic          CLEAR;
    logic          IRQ_EN;
    logic [DW-1:0] OP1_IN;
    logic [DW-1:0] OP2_IN;
    logic [OW-1:0] OP_SEL_IN;
    logic          FPU_VALID;
    logic          FPU_READY;
    logic [DW-1:0] FPU_OP1;
    logic [DW-1:0] FPU_OP2;
    logic [OW-1:0] FPU_OPSEL;
    logic          FPU_RESULT_VALID;
    logic [DW-1:0] FPU_RESULT;
    logic [FW-1:0] FPU_FLAGS;
    logic [DW-1:0] RESULT;
    logic [FW-1:0] FLAGS;
    logic          BUSY;
    logic          DONE;
    logic          TIMEOUT_ERR;
    logic          ILLEGAL_OP;
    logic          OVERRUN;
    logic          IRQ;

    fpu_op_sequencer #(
        .DATA_WIDTH     (DW),
        .OPSEL_WIDTH    (OW),
        .FLAG_WIDTH     (FW),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .CLK              (CLK),
        .RST              (RST),
        .START            (START),
        .CLEAR            (CLEAR),
        .IRQ_EN           (IRQ_EN),
        .OP1_IN           (OP1_IN),
        .OP2_IN           (OP2_IN),
        .OP_SEL_IN        (OP_SEL_IN),
        .FPU_VALID        (FPU_VALID),
        .FPU_READY        (FPU_READY),
        .FPU_OP1          (FPU_OP1),
        .FPU_OP2          (FPU_OP2),
        .FPU_OPSEL        (FPU_OPSEL),
        .FPU_RESULT_VALID (FPU_RESULT_VALID),
        .FPU_RESULT       (FPU_RESULT),
        .FPU_FLAGS        (FPU_FLAGS),
        .RESULT           (RESULT),
        .FLAGS            (FLAGS),
        .BUSY             (BUSY),
        .DONE             (DONE),
        .TIMEOUT_ERR      (TIMEOUT_ERR),
        .ILLEGAL_OP       (ILLEGAL_OP),
        .OVERRUN          (OVERRUN),
        .IRQ              (IRQ)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [DW-1:0] op1;
        logic [DW-1:0] op2;
        logic [OW-1:0] opsel;
        int            at;
    } issue_t;

    typedef struct {
        logic          done;
        logic          to;
        logic          ill;
        logic          ovr;
        logic          irq;
        logic [DW-1:0] result;
        logic [FW-1:0] flags;
        int            at;
    } status_t;

    issue_t  issue_q[$];
    status_t stat_q[$];

    // Reference view of the register-side state.
    logic          m_done, m_to, m_ill, m_ovr;
    logic [DW-1:0] m_result;
    logic [FW-1:0] m_flags;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: checks each issue handshake and each status event against
    // the queued expectations.
    logic          prev_busy  = 1'b0;
    logic          prev_ill   = 1'b0;
    logic          prev_valid = 1'b0;
    logic [DW-1:0] prev_op1;
    logic [OW-1:0] prev_opsel;
    always @(negedge CLK) begin
        issue_t  ie;
        status_t se;
        if (FPU_VALID === 1'b1 && FPU_READY === 1'b1) begin
            if (issue_q.size() == 0) begin
                check("unexpected_issue", 64'd1, 64'd0);
            end else begin
                ie = issue_q.pop_front();
                check("issue_op1",   64'(FPU_OP1),   64'(ie.op1));
                check("issue_op2",   64'(FPU_OP2),   64'(ie.op2));
                check("issue_opsel", 64'(FPU_OPSEL), 64'(ie.opsel));
                check("issue_cycle", 64'(cyc),       64'(ie.at));
            end
        end
        if (prev_valid && FPU_VALID === 1'b1) begin
            check("op1_hold",   64'(FPU_OP1),   64'(prev_op1));
            check("opsel_hold", 64'(FPU_OPSEL), 64'(prev_opsel));
        end
        if ((prev_busy && BUSY === 1'b0) ||
            (!prev_ill && ILLEGAL_OP === 1'b1 && BUSY === 1'b0)) begin
            if (stat_q.size() == 0) begin
                check("unexpected_status", 64'd1, 64'd0);
            end else begin
                se = stat_q.pop_front();
                check("st_done",    64'(DONE),        64'(se.done));
                check("st_timeout", 64'(TIMEOUT_ERR), 64'(se.to));
                check("st_illegal", 64'(ILLEGAL_OP),  64'(se.ill));
                check("st_overrun", 64'(OVERRUN),     64'(se.ovr));
                check("st_irq",     64'(IRQ),         64'(se.irq));
                check("st_result",  64'(RESULT),      64'(se.result));
                check("st_flags",   64'(FLAGS),       64'(se.flags));
                check("st_cycle",   64'(cyc),         64'(se.at));
            end
        end
        prev_busy  = (BUSY === 1'b1);
        prev_ill   = (ILLEGAL_OP === 1'b1);
        prev_valid = (FPU_VALID === 1'b1);
        prev_op1   = FPU_OP1;
        prev_opsel = FPU_OPSEL;
    end

    // One legal operation. r: cycles FPU_READY is withheld after issue;
    // w: cycles in WAIT before the result pulse. Timeline relative to START
    // at rel 0: request visible at 1, READY at 1+r, WAIT from 2+r, result at
    // 2+r+w. The operation times out at rel T unless the result lands by then.
    task automatic run_txn(input int r, input int w, input bit has_res,
                           input bit has_ovr, input int unsigned ovr_pick,
                           input bit clr_end, input logic [OW-1:0] opsel,
                           input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [DW-1:0] res, input logic [FW-1:0] fl,
                           input logic irq_en);
        int  res_rel  = 2 + r + w;
        bit  done_ok  = has_res && (res_rel <= T);
        bit  shake    = (1 + r) < T;
        int  end_rel  = done_ok ? res_rel + 1 : T + 1;
        int  ovr_rel  = 1 + int'(ovr_pick % 32'(end_rel - 1));
        int  len;
        int  s        = cyc;
        len = end_rel;
        if (res_rel > len) len = res_rel;
        if (1 + r > len)   len = 1 + r;
        len = len + 2;
        IRQ_EN = irq_en;

        if (shake) issue_q.push_back('{a, b, opsel, s + 1 + r});
        m_done = done_ok;
        m_to   = !done_ok;
        m_ill  = 1'b0;
        if (has_ovr) m_ovr = 1'b1;
        if (clr_end && !(has_ovr && ovr_rel == end_rel - 1)) m_ovr = 1'b0;
        if (done_ok) begin
            m_result = res;
            m_flags  = fl;
        end
        stat_q.push_back('{m_done, m_to, m_ill, m_ovr,
                           irq_en & (m_done | m_to | m_ill),
                           m_result, m_flags, s + end_rel});

        for (int rel = 0; rel < len; rel++) begin
            START = (rel == 0) || (has_ovr && rel == ovr_rel);
            if (rel == 0) begin
                OP1_IN    = a;
                OP2_IN    = b;
                OP_SEL_IN = opsel;
            end else begin
                OP1_IN    = $urandom;
                OP2_IN    = $urandom;
                OP_SEL_IN = OW'($urandom);
            end
            FPU_READY        = (rel == 1 + r);
            FPU_RESULT_VALID = has_res && (rel == res_rel);
            FPU_RESULT       = FPU_RESULT_VALID ? res : DW'($urandom);
            FPU_FLAGS        = FPU_RESULT_VALID ? fl  : FW'($urandom);
            CLEAR            = clr_end && (rel == end_rel - 1);
            if (shake && rel == 2 + r) check("valid_drop", 64'(FPU_VALID), 64'd0);
            tick();
        end
        START            = 1'b0;
        FPU_READY        = 1'b0;
        FPU_RESULT_VALID = 1'b0;
        CLEAR            = 1'b0;
    endtask

    // Clear stickies, then request an unsupported op code.
    task automatic run_illegal(input logic irq_en);
        int s;
        CLEAR = 1'b1;
        tick();
        CLEAR = 1'b0;
        m_done = 1'b0; m_to = 1'b0; m_ill = 1'b0; m_ovr = 1'b0;
        IRQ_EN    = irq_en;
        s         = cyc;
        START     = 1'b1;
        OP_SEL_IN = OW'($urandom_range(5, 7));
        OP1_IN    = $urandom;
        m_ill     = 1'b1;
        stat_q.push_back('{1'b0, 1'b0, 1'b1, 1'b0, irq_en, m_result, m_flags, s + 1});
        tick();
        START = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("illegal_no_valid", 64'(FPU_VALID), 64'd0);
            check("illegal_not_busy", 64'(BUSY),      64'd0);
            tick();
        end
    endtask

    task automatic idle_gap();
        int n = $urandom_range(1, 3);
        for (int k = 0; k < n; k++) begin
            CLEAR = ($urandom_range(0, 9) == 0);
            if (CLEAR) begin
                m_done = 1'b0; m_to = 1'b0; m_ill = 1'b0; m_ovr = 1'b0;
            end
            tick();
        end
        CLEAR = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int            r, w;
        bit            has_res;
        int            s;
        logic [DW-1:0] a, b;

        RST = 1'b1; START = 1'b0; CLEAR = 1'b0; IRQ_EN = 1'b1;
        OP1_IN = '0; OP2_IN = '0; OP_SEL_IN = '0;
        FPU_READY = 1'b0; FPU_RESULT_VALID = 1'b0; FPU_RESULT = '0; FPU_FLAGS = '0;
        m_done = 1'b0; m_to = 1'b0; m_ill = 1'b0; m_ovr = 1'b0;
        m_result = '0; m_flags = '0;
        repeat (3) tick();
        check("rst_valid",   64'(FPU_VALID),   64'd0);
        check("rst_op1",     64'(FPU_OP1),     64'd0);
        check("rst_opsel",   64'(FPU_OPSEL),   64'd0);
        check("rst_result",  64'(RESULT),      64'd0);
        check("rst_flags",   64'(FLAGS),       64'd0);
        check("rst_busy",    64'(BUSY),        64'd0);
        check("rst_done",    64'(DONE),        64'd0);
        check("rst_timeout", 64'(TIMEOUT_ERR), 64'd0);
        check("rst_illegal", 64'(ILLEGAL_OP),  64'd0);
        check("rst_overrun", 64'(OVERRUN),     64'd0);
        check("rst_irq",     64'(IRQ),         64'd0);
        RST = 1'b0;
        tick();

        // Normal op: 1.0 + 2.0 = 3.0, DONE four cycles after START.
        run_txn(0, 1, 1'b1, 1'b0, 0, 1'b0, 3'd0,
                32'h3F800000, 32'h40000000, 32'h40400000, 5'd0, 1'b1);
        idle_gap();
        // Backpressure: READY withheld 10 cycles.
        run_txn(10, 2, 1'b1, 1'b0, 0, 1'b0, 3'd2,
                $urandom, $urandom, $urandom, 5'h11, 1'b1);
        idle_gap();
        // Timeout with no result; RESULT must keep the previous value.
        run_txn(0, 0, 1'b0, 1'b0, 0, 1'b0, 3'd3,
                $urandom, $urandom, $urandom, 5'h1F, 1'b1);
        idle_gap();
        // Result on the expiry cycle: completion wins.
        run_txn(0, T - 2, 1'b1, 1'b0, 0, 1'b0, 3'd1,
                $urandom, $urandom, $urandom, 5'h04, 1'b0);
        idle_gap();
        // Result one cycle after expiry: timeout, late pulse ignored.
        run_txn(1, T - 2, 1'b1, 1'b0, 0, 1'b0, 3'd4,
                $urandom, $urandom, $urandom, 5'h02, 1'b1);
        idle_gap();
        // READY never arrives while valid: timeout out of ISSUE.
        run_txn(T + 2, 0, 1'b1, 1'b0, 0, 1'b0, 3'd0,
                $urandom, $urandom, $urandom, 5'h01, 1'b1);
        idle_gap();
        // START while in WAIT plus CLEAR coincident with DONE being set.
        run_txn(0, 4, 1'b1, 1'b1, 3, 1'b1, 3'd2,
                $urandom, $urandom, $urandom, 5'h08, 1'b1);
        idle_gap();
        run_illegal(1'b1);
        idle_gap();

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 19))
                0:       r = T + 2;
                1, 2:    r = $urandom_range(0, T - 3);
                default: r = $urandom_range(0, 4);
            endcase
            has_res = ($urandom_range(0, 6) != 0);
            case ($urandom_range(0, 9))
                0:       w = (r <= T - 3) ? T - 2 - r : 0;
                1:       w = (r <= T - 3) ? T - 1 - r : 0;
                default: w = $urandom_range(0, 5);
            endcase
            if ($urandom_range(0, 9) == 0) begin
                run_illegal($urandom_range(0, 1) == 1);
            end else begin
                run_txn(r, w, has_res, ($urandom_range(0, 3) == 0), $urandom,
                        ($urandom_range(0, 4) == 0), OW'($urandom_range(0, 4)),
                        $urandom, $urandom, $urandom, FW'($urandom),
                        $urandom_range(0, 1) == 1);
            end
            idle_gap();
        end

        // Reset in the middle of WAIT, then a stale result pulse.
        s = cyc;
        a = $urandom;
        b = $urandom;
        IRQ_EN = 1'b1;
        START = 1'b1; OP1_IN = a; OP2_IN = b; OP_SEL_IN = 3'd2;
        issue_q.push_back('{a, b, 3'd2, s + 1});
        tick();
        START = 1'b0; FPU_READY = 1'b1;
        tick();
        FPU_READY = 1'b0;
        tick();
        RST = 1'b1;
        m_done = 1'b0; m_to = 1'b0; m_ill = 1'b0; m_ovr = 1'b0;
        m_result = '0; m_flags = '0;
        stat_q.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, s + 4});
        tick();
        RST = 1'b0;
        check("mid_rst_valid", 64'(FPU_VALID), 64'd0);
        check("mid_rst_op1",   64'(FPU_OP1),   64'd0);
        check("mid_rst_opsel", 64'(FPU_OPSEL), 64'd0);
        FPU_RESULT_VALID = 1'b1; FPU_RESULT = $urandom; FPU_FLAGS = 5'h1F;
        tick();
        FPU_RESULT_VALID = 1'b0;
        tick();
        check("late_result_done",   64'(DONE),   64'd0);
        check("late_result_value",  64'(RESULT), 64'd0);
        check("late_result_flags",  64'(FLAGS),  64'd0);
        check("late_result_busy",   64'(BUSY),   64'd0);
        check("late_result_irq",    64'(IRQ),    64'd0);
        run_txn(1, 1, 1'b1, 1'b0, 0, 1'b0, 3'd3,
                $urandom, $urandom, $urandom, 5'h10, 1'b1);

        repeat (4) tick();
        check("issue_queue_drained",  64'(issue_q.size()), 64'd0);
        check("status_queue_drained", 64'(stat_q.size()),  64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_fpu_op_sequencer
`default_nettype wire

// File: doc/fpu_op_sequencer.md
# fpu_op_sequencer

Controller that sequences one operation on the APB FPU datapath. It latches the operand and op-select values from the FPU register bank on a start pulse and issues them to the FPU core over a valid/ready handshake. It then waits for the result under a watchdog timeout and captures the result and flags. It presents busy/done/error status and an interrupt back to the APB side.

## Interface
- DATA_WIDTH, 32, operand/result width
- OPSEL_WIDTH, 3, op-select width
- FLAG_WIDTH, 5, IEEE exception flags (NV, DZ, OF, UF, NX)
- TIMEOUT_CYCLES, 64, watchdog limit in cycles (≥2)
- CLK  in  1  clock; single clock domain
- RST  in  1  reset, synchronous, active-high
- START  in  1  one-cycle request to run the current operands
- CLEAR  in  1  one-cycle clear of the DONE/TIMEOUT_ERR/ILLEGAL_OP/OVERRUN sticky bits
- IRQ_EN  in  1  interrupt enable
- OP1_IN, OP2_IN  in  DATA_WIDTH  operands from the register bank
- OP_SEL_IN  in  OPSEL_WIDTH  operation code from the register bank
- FPU_VALID  out  1  issue request to the FPU core
- FPU_READY  in  1  FPU core accepts the issue
- FPU_OP1, FPU_OP2  out  DATA_WIDTH  latched operands
- FPU_OPSEL  out  OPSEL_WIDTH  latched op code
- FPU_RESULT_VALID  in  1  result/flags valid, one-cycle pulse
- FPU_RESULT  in  DATA_WIDTH; FPU_FLAGS  in  FLAG_WIDTH
- RESULT  out  DATA_WIDTH; FLAGS  out  FLAG_WIDTH  captured outputs
- BUSY, DONE, TIMEOUT_ERR, ILLEGAL_OP, OVERRUN  out  1  status
- IRQ  out  1  IRQ_EN & (DONE | TIMEOUT_ERR | ILLEGAL_OP)

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE, START, OP_SEL_IN legal (0..4 = ADD, SUB, MUL, DIV, SQRT):
  - latch OP1, OP2, and OP_SEL into the FPU_* registers
  - clear the watchdog; go to ISSUE
- IDLE, START, OP_SEL_IN 5..7: set ILLEGAL_OP; stay in IDLE; nothing is issued.
- ISSUE: FPU_VALID=1 and operands are held stable. On FPU_READY go to WAIT.
- WAIT: on FPU_RESULT_VALID:
  - capture RESULT/FLAGS
  - set DONE; go to IDLE
- FPU_RESULT_VALID outside WAIT is ignored.
- Watchdog:
  - counts every cycle in ISSUE or WAIT
  - at count TIMEOUT_CYCLES-1 with no completion that cycle: set TIMEOUT_ERR, go to IDLE, drop FPU_VALID
  - RESULT/FLAGS keep their previous values
- Completion in the same cycle as the timeout: completion wins; TIMEOUT_ERR is not set.
- START while BUSY is ignored and sets OVERRUN. The latched operands do not change.
- BUSY = (state != IDLE).
- Sticky bits:
  - set by their events, cleared by CLEAR
  - set and CLEAR in the same cycle: set wins
- Accepted START in IDLE clears DONE, TIMEOUT_ERR and ILLEGAL_OP. OVERRUN is kept.
- RST at any point, including mid-operation:
  - state goes to IDLE
  - all outputs go to 0 (FPU_VALID, FPU_OP1/2, FPU_OPSEL, RESULT, FLAGS, BUSY, all sticky bits, IRQ)
  - the watchdog goes to 0
  - an in-flight FPU result arriving after reset is ignored.

## Timing
- All outputs are registered except IRQ and BUSY. Both are combinational from registered state only.
- START sampled at cycle 0 → FPU_VALID=1 and BUSY=1 at cycle 1.
- FPU_READY high at cycle k in ISSUE → WAIT at k+1. FPU_VALID is low at k+1.
- FPU_RESULT_VALID at cycle n in WAIT → RESULT/FLAGS/DONE valid and BUSY=0 at n+1. A new START is accepted at n+1.
- Minimum issue-to-done with ready and result both immediate: START@0, VALID@1, READY@1, RESULT_VALID@2, DONE@3.
- Timeout: START@0 with no handshake → TIMEOUT_ERR=1 at cycle TIMEOUT_CYCLES+1.

## Structure
- The shared package fpu_pkg holds:
  - fpu_seq_state_t enum (IDLE, ISSUE, WAIT)
  - op-code constants FPU_ADD=0, FPU_SUB=1, FPU_MUL=2, FPU_DIV=3, FPU_SQRT=4, FPU_OP_LAST=4
  - FPU_FLAG_WIDTH=5
- Sub-module fpu_watchdog, a natural split:
  - parameter TIMEOUT_CYCLES
  - inputs clr and run; output expired
  - width $clog2(TIMEOUT_CYCLES)
  - the counter saturates and does not wrap.

## Test plan
- Normal op: START with OP1=0x3F800000, OP2=0x40000000, OP_SEL=0, READY immediate; 2 cycles later RESULT_VALID with 0x40400000, flags 0 → FPU_VALID@1, DONE@4, RESULT=0x40400000, IRQ=1 if IRQ_EN.
- Backpressure: READY held low 10 cycles → FPU_VALID and FPU_OP1/2/OPSEL stable throughout; WAIT entered the cycle after READY.
- Timeout with TIMEOUT_CYCLES=16: READY=1, no RESULT_VALID → TIMEOUT_ERR@17, BUSY=0, RESULT unchanged; RESULT_VALID on the same cycle as expiry → DONE=1, TIMEOUT_ERR=0.
- Illegal and overrun:
  - START with OP_SEL=6 → ILLEGAL_OP=1, FPU_VALID never asserts
  - START during WAIT → OVERRUN=1, FPU_OP1 unchanged
  - CLEAR coincident with DONE set → DONE=1
- Reset mid-WAIT: RST one cycle, then a late RESULT_VALID → all outputs 0, DONE stays 0, next START runs normally.
